mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the
// shared data-memory port arbiter.
//   i_*   : instruction-fetch requester (req/addr in, ack/rdata out)
//   d_*   : load/store requester (req/we/addr/func3/wdata in, ack/rdata out)
//   mem_* : single-ported memory (read/write/addr/func3/wdata out, rdata in)
//   busy  : arbiter is mid-access, used by pipeline stall logic
// With MISALIGN_TRAP_EN defined, d_err is added for misaligned data accesses.
// The "slave" modport is the arbiter's view; "master" is the surrounding
// core/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_func3;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
`ifdef MISALIGN_TRAP_EN
  logic              d_err;
`endif

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_func3;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_func3, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
`ifdef MISALIGN_TRAP_EN
    output d_err,
`endif
    output mem_read, mem_write, mem_addr, mem_func3, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_func3, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
`ifdef MISALIGN_TRAP_EN
    input  d_err,
`endif
    input  mem_read, mem_write, mem_addr, mem_func3, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one byte-addressed data memory between instruction fetch
// and load/store. Every access runs arbitrate (IDLE) -> issue -> respond,
// giving a 2-cycle request-to-ack latency and 3 cycles per access.
// Data wins arbitration unless fetch has been passed over STARVE_MAX times
// in a row while waiting.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (fetch, load/store and memory signals)
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word data
// accesses skip the memory and answer with d_ack + d_err.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(STARVE_MAX);
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, ISSUE_I, ISSUE_D, RESP} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
  logic [2:0]        iss_func3_q, iss_func3_d;
  logic              iss_we_q, iss_we_d;
  logic [31:0]       iss_wdata_q, iss_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              data_win;
  logic              d_trap;
`ifdef MISALIGN_TRAP_EN
  logic              d_err_q, d_err_d;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return (a != 2'b00);
      default:        return 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    iss_addr_d  = iss_addr_q;
    iss_func3_d = iss_func3_q;
    iss_we_d    = iss_we_q;
    iss_wdata_d = iss_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    d_trap      = 1'b0;
`ifdef MISALIGN_TRAP_EN
    d_err_d     = 1'b0;
    d_trap      = misaligned(bus.d_func3, bus.d_addr[1:0]);
`endif
    // Fetch overrides data only once it has been starved STARVE_MAX times.
    data_win = bus.d_req && !(streak_q == STREAK_SAT && bus.i_req);

    unique case (state_q)
      IDLE: begin
        if (!bus.i_req) streak_d = '0;
        if (data_win) begin
          if (bus.i_req && streak_q != STREAK_SAT) streak_d = streak_q + 1'b1;
          iss_addr_d  = bus.d_addr;
          iss_func3_d = bus.d_func3;
          iss_we_d    = bus.d_we;
          iss_wdata_d = bus.d_wdata;
          if (d_trap) begin
            // Misaligned: answer straight away without touching memory.
            state_d   = RESP;
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
`ifdef MISALIGN_TRAP_EN
            d_err_d   = 1'b1;
`endif
          end else begin
            state_d = ISSUE_D;
          end
        end else if (bus.i_req) begin
          streak_d    = '0;
          iss_addr_d  = bus.i_addr;
          iss_func3_d = F3_WORD;
          iss_we_d    = 1'b0;
          iss_wdata_d = '0;
          state_d     = ISSUE_I;
        end
      end
      ISSUE_I: begin
        i_ack_d   = 1'b1;
        i_rdata_d = bus.mem_rdata;
        state_d   = RESP;
      end
      ISSUE_D: begin
        d_ack_d   = 1'b1;
        d_rdata_d = iss_we_q ? 32'h0 : bus.mem_rdata;
        state_d   = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      iss_addr_q  <= '0;
      iss_func3_q <= '0;
      iss_we_q    <= 1'b0;
      iss_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MISALIGN_TRAP_EN
      d_err_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      iss_addr_q  <= iss_addr_d;
      iss_func3_q <= iss_func3_d;
      iss_we_q    <= iss_we_d;
      iss_wdata_q <= iss_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MISALIGN_TRAP_EN
      d_err_q     <= d_err_d;
`endif
    end
  end

  // Strobes are gated by rst so a store caught mid-issue never commits.
  assign bus.mem_read  = !rst && (state_q == ISSUE_I || state_q == ISSUE_D) && !iss_we_q;
  assign bus.mem_write = !rst && (state_q == ISSUE_D) && iss_we_q;
  assign bus.mem_addr  = iss_addr_q;
  assign bus.mem_func3 = iss_func3_q;
  assign bus.mem_wdata = iss_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef MISALIGN_TRAP_EN
  assign bus.d_err     = d_err_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(8)) bus ();
  mem_port_arbiter #(.ADDR_W(8), .STARVE_MAX(SM)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [2:0]  f3;
    logic [31:0] wd;
  } dreq_t;

  logic [7:0] mem  [256];
  logic [7:0] refm [256];
  logic [7:0] ra;

  logic [7:0] iq[$];
  dreq_t      dq[$];
  logic [7:0] glog[$];
  logic [31:0] dlog[$];
  logic [31:0] ilog[$];

  int cyc, n_chk, n_err, gap, rst_hit, age, streak;
  bit act, g_pend, t_port, t_we, t_trap, i_act, d_act;
  bit rand_rst, rand_push, rst_on_store, log_on, prev_rst;
  logic [7:0]  t_addr;
  logic [2:0]  t_f3;
  logic [31:0] t_wd, t_rdata, m_ir, m_dr;

  function automatic logic [31:0] ext32(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory: combinational read with width/sign handling done by func3.
  always_comb begin
    ra = bus.mem_addr;
    bus.mem_rdata = ext32({mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]}, bus.mem_func3);
  end

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] f3);
    return ext32({refm[a + 8'd3], refm[a + 8'd2], refm[a + 8'd1], refm[a]}, f3);
  endfunction

  task automatic mem_store(input bit to_ref, input logic [7:0] a, input logic [2:0] f3,
                           input logic [31:0] wd);
    int n;
    logic [7:0] ad;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) begin
      ad = a + 8'(k);
      if (to_ref) refm[ad] = wd[8*k +: 8];
      else        mem[ad]  = wd[8*k +: 8];
    end
  endtask

`ifdef MISALIGN_TRAP_EN
  function automatic bit misal(input logic [2:0] f3, input logic [7:0] a);
    return ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
  endfunction
`endif

  function automatic dreq_t rand_dreq();
    dreq_t r;
    r.we   = 1'($urandom);
    r.addr = 8'($urandom);
    r.wd   = $urandom;
    r.f3   = 3'($urandom_range(2));
    if (!r.we && r.f3 != 3'd2 && $urandom_range(1) == 1) r.f3[2] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: advance the transaction model, compare, drive requesters.
  task automatic step();
    bit issue, resp, rst_now;
    int dur;
    dreq_t r;
    @(negedge clk);
    cyc++;
    if (prev_rst) begin
      act = 0; streak = 0; m_ir = '0; m_dr = '0;
    end else if (g_pend) begin
      act = 1; age = 1;
    end else if (act) begin
      age++;
      if (age > (t_trap ? 1 : 2)) act = 0;
    end
    g_pend = 0;
    dur   = t_trap ? 1 : 2;
    issue = act && age == 1 && !t_trap;
    resp  = act && age == dur;
    if (resp) begin
      if (t_port) m_dr = t_rdata;
      else        m_ir = t_rdata;
    end
    rst_now = (rand_rst && $urandom_range(99) == 0) ||
              (rst_on_store && issue && t_port && t_we);
    if (rst_now && rst_on_store) begin rst_hit++; rst_on_store = 0; end
    rst = rst_now;
    #1;
    chk("busy", 32'(bus.busy), 32'(act));
    chk("mem_read", 32'(bus.mem_read), 32'(issue && !t_we && !rst_now));
    chk("mem_write", 32'(bus.mem_write), 32'(issue && t_we && !rst_now));
    if (issue) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(t_addr));
      chk("mem_func3", 32'(bus.mem_func3), 32'(t_f3));
      if (t_we) chk("mem_wdata", bus.mem_wdata, t_wd);
    end
    chk("i_ack", 32'(bus.i_ack), 32'(resp && !t_port));
    chk("d_ack", 32'(bus.d_ack), 32'(resp && t_port));
    chk("i_rdata", bus.i_rdata, m_ir);
    chk("d_rdata", bus.d_rdata, m_dr);
`ifdef MISALIGN_TRAP_EN
    chk("d_err", 32'(bus.d_err), 32'(resp && t_trap));
`endif
    chk("dual_ack", 32'(bus.i_ack & bus.d_ack), 32'h0);

    if (bus.mem_write) mem_store(0, bus.mem_addr, bus.mem_func3, bus.mem_wdata);
    if (issue && !rst_now) begin
      if (t_we) mem_store(1, t_addr, t_f3, t_wd);
      else      t_rdata = ref_load(t_addr, t_f3);
    end
    if (log_on && bus.i_ack) begin glog.push_back("I"); ilog.push_back(bus.i_rdata); end
    if (log_on && bus.d_ack) begin glog.push_back("D"); dlog.push_back(bus.d_rdata); end

    if (rst_now) begin
      i_act = 0; d_act = 0;
    end else begin
      if (resp && !t_port) i_act = 0;
      if (resp && t_port)  d_act = 0;
      // Wiggle the granted port's fields once it is past sampling.
      if (issue && !t_port) bus.i_addr = 8'($urandom);
      if (issue && t_port) begin
        bus.d_addr = 8'($urandom); bus.d_func3 = 3'($urandom);
        bus.d_we = 1'($urandom); bus.d_wdata = $urandom;
      end
      if (rand_push && iq.size() == 0 && $urandom_range(3) == 0) iq.push_back(8'($urandom));
      if (rand_push && dq.size() == 0 && $urandom_range(2) == 0) dq.push_back(rand_dreq());
      if (!i_act && iq.size() != 0 && $urandom_range(99) >= gap) begin
        bus.i_addr = iq.pop_front(); i_act = 1;
      end
      if (!d_act && dq.size() != 0 && $urandom_range(99) >= gap) begin
        r = dq.pop_front();
        bus.d_we = r.we; bus.d_addr = r.addr; bus.d_func3 = r.f3; bus.d_wdata = r.wd;
        d_act = 1;
      end
    end
    bus.i_req = i_act;
    bus.d_req = d_act;

    if (!rst_now && !act) begin
      if (bus.d_req && !(streak == SM && bus.i_req)) begin
        g_pend = 1; t_port = 1; t_we = bus.d_we; t_addr = bus.d_addr;
        t_f3 = bus.d_func3; t_wd = bus.d_wdata; t_rdata = '0; t_trap = 0;
`ifdef MISALIGN_TRAP_EN
        t_trap = misal(bus.d_func3, bus.d_addr);
`endif
        streak = bus.i_req ? ((streak + 1 > SM) ? SM : streak + 1) : 0;
      end else if (bus.i_req) begin
        g_pend = 1; t_port = 0; t_we = 0; t_addr = bus.i_addr;
        t_f3 = 3'b010; t_wd = '0; t_rdata = '0; t_trap = 0;
        streak = 0;
      end else begin
        streak = 0;
      end
    end
    prev_rst = rst_now;
  endtask

  task automatic drain(input int budget);
    int n;
    bit pending;
    n = 0;
    pending = 1;
    while (pending && n < budget) begin
      step();
      n++;
      pending = iq.size() != 0 || dq.size() != 0 || i_act || d_act || act || g_pend;
    end
    chk("drain_timeout", 32'(pending), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    string ord;
    int diffs;
    logic [7:0] b;
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_func3 = '0; bus.d_wdata = '0;
    for (int a = 0; a < 256; a++) begin
      b = 8'($urandom); mem[a] = b; refm[a] = b;
    end
    for (int a = 0; a < 16; a++) begin mem[a] = 8'h00; refm[a] = 8'h00; end
    mem[0] = 8'h02; refm[0] = 8'h02;

    repeat (2) @(negedge clk);
    chk("rst_i_ack", 32'(bus.i_ack), 32'h0);
    chk("rst_d_ack", 32'(bus.d_ack), 32'h0);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'h0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_func3", 32'(bus.mem_func3), 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_d_err", 32'(bus.d_err), 32'h0);
`endif
    prev_rst = 1;

    // Fetch of word 0x00000002.
    log_on = 1;
    iq.push_back(8'h00);
    drain(50);
    chk("fetch_cnt", 32'(ilog.size()), 32'd1);
    if (ilog.size() == 1) chk("fetch_word", ilog[0], 32'h00000002);

    // Store then loads of several widths.
    dlog.delete();
    dq.push_back('{we: 1'b1, addr: 8'h08, f3: 3'b010, wd: 32'hDEADBEEF});
    dq.push_back('{we: 1'b0, addr: 8'h08, f3: 3'b010, wd: 32'h0});
    dq.push_back('{we: 1'b0, addr: 8'h0B, f3: 3'b000, wd: 32'h0});
    dq.push_back('{we: 1'b0, addr: 8'h0B, f3: 3'b100, wd: 32'h0});
    drain(100);
    chk("ls_cnt", 32'(dlog.size()), 32'd4);
    if (dlog.size() == 4) begin
      chk("sw_rdata", dlog[0], 32'h00000000);
      chk("lw_rdata", dlog[1], 32'hDEADBEEF);
      chk("lb_rdata", dlog[2], 32'hFFFFFFDE);
      chk("lbu_rdata", dlog[3], 32'h000000DE);
    end

    // Both ports held continuously: fetch forced in after four data grants.
    glog.delete();
    for (int k = 0; k < 2; k++) iq.push_back(8'($urandom));
    for (int k = 0; k < 8; k++)
      dq.push_back('{we: 1'b0, addr: {6'($urandom), 2'b00}, f3: 3'b010, wd: 32'h0});
    drain(200);
    ord = "DDDDIDDDDI";
    chk("order_cnt", 32'(glog.size()), 32'd10);
    if (glog.size() == 10)
      for (int k = 0; k < 10; k++) chk($sformatf("order%0d", k), 32'(glog[k]), 32'(ord[k]));
    log_on = 0;

    // Reset lands on the issue cycle of a store.
    rst_on_store = 1;
    dq.push_back('{we: 1'b1, addr: 8'h0C, f3: 3'b010, wd: 32'h11223344});
    drain(50);
    chk("rst_hit", 32'(rst_hit), 32'd1);
    chk("rst_store_mem", {mem[15], mem[14], mem[13], mem[12]}, 32'h0);

    // Misaligned word store.
    dq.push_back('{we: 1'b1, addr: 8'h02, f3: 3'b010, wd: 32'hA5A55A5A});
    drain(50);
`ifdef MISALIGN_TRAP_EN
    chk("misal_mem", {mem[5], mem[4], mem[3], mem[2]}, 32'h00000000);
`else
    chk("misal_mem", {mem[5], mem[4], mem[3], mem[2]}, 32'hA5A55A5A);
`endif

    // Random traffic with occasional reset.
    gap = 30; rand_rst = 1; rand_push = 1;
    repeat (2000) step();
    rand_push = 0; rand_rst = 0;
    drain(300);

    diffs = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== refm[a]) diffs++;
    chk("mem_image", 32'(diffs), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
